// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the instruction-fetch (IFU)
// and load/store (LSU) requesters, one transaction at a time.
// Optional build macro ARB_ROUND_ROBIN_EN: ties alternate between requesters
// instead of always going to the LSU.
module mem_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  input  logic                ifu_flush,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rsp_err,
  output logic [31:0]         ifu_grant_cnt,
  output logic [31:0]         lsu_grant_cnt
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

  state_t          state;
  owner_t          owner;
  logic            drop;
  logic [TO_W-1:0] to_cnt;
`ifdef ARB_ROUND_ROBIN_EN
  owner_t          last_grant;
`endif

  logic ifu_ok;
  logic grant_ifu;
  logic grant_lsu;
  logic flush_hit;
  logic drop_now;
  logic rsp_done;
  logic timed_out;

  // Grant decision in IDLE; a flushed IFU request is not eligible
  always_comb begin
    ifu_ok    = ifu_req_valid & ~ifu_flush;
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == S_IDLE && !reset) begin
      if (ifu_ok && lsu_req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (last_grant == OWN_IFU) grant_lsu = 1'b1;
        else                       grant_ifu = 1'b1;
`else
        grant_lsu = 1'b1;
`endif
      end else if (ifu_ok) begin
        grant_ifu = 1'b1;
      end else if (lsu_req_valid) begin
        grant_lsu = 1'b1;
      end
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  // Response qualification: a flush arriving with the response still drops it
  always_comb begin
    flush_hit = ifu_flush && (owner == OWN_IFU) && (state != S_IDLE);
    drop_now  = drop | flush_hit;
    timed_out = (to_cnt == TO_LAST);
    rsp_done  = (state == S_RSP) && (mem_rsp_valid || timed_out);
  end

  // Transaction FSM, bus registers, response pulses and grant counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      owner         <= OWN_IFU;
      drop          <= 1'b0;
      to_cnt        <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant    <= OWN_IFU;
`endif
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      ifu_rsp_valid <= 1'b0;
      ifu_rdata     <= '0;
      ifu_rsp_err   <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      lsu_rdata     <= '0;
      lsu_rsp_err   <= 1'b0;
      ifu_grant_cnt <= '0;
      lsu_grant_cnt <= '0;
    end else begin
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          drop <= 1'b0;
          if (grant_lsu) begin
            mem_addr      <= lsu_addr;
            mem_wen       <= lsu_wen;
            mem_wdata     <= lsu_wdata;
            mem_wmask     <= lsu_wmask;
            owner         <= OWN_LSU;
            lsu_grant_cnt <= lsu_grant_cnt + 32'd1;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant    <= OWN_LSU;
`endif
            mem_req_valid <= 1'b1;
            state         <= S_REQ;
          end else if (grant_ifu) begin
            mem_addr      <= ifu_addr;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            owner         <= OWN_IFU;
            ifu_grant_cnt <= ifu_grant_cnt + 32'd1;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant    <= OWN_IFU;
`endif
            mem_req_valid <= 1'b1;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (flush_hit) drop <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            to_cnt        <= '0;
            state         <= S_RSP;
          end
        end
        S_RSP: begin
          to_cnt <= to_cnt + 1'b1;
          if (flush_hit) drop <= 1'b1;
          if (rsp_done) begin
            // A real response takes precedence over a coincident timeout
            if (owner == OWN_IFU) begin
              ifu_rsp_valid <= ~drop_now;
              ifu_rdata     <= mem_rsp_valid ? mem_rdata : '0;
              ifu_rsp_err   <= mem_rsp_valid ? mem_rsp_err : 1'b1;
            end else begin
              lsu_rsp_valid <= 1'b1;
              lsu_rdata     <= mem_rsp_valid ? mem_rdata : '0;
              lsu_rsp_err   <= mem_rsp_valid ? mem_rsp_err : 1'b1;
            end
            drop  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: the bench plays the memory bus and
// both requesters, predicting grants, bus fields and responses from the
// arbitration and response rules.
module tb_mem_bus_arbiter;

  localparam int TO = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ifu_req_valid = 1'b0, ifu_req_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_flush = 1'b0;
  logic        ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid = 1'b0, lsu_req_ready;
  logic [31:0] lsu_addr = '0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid, mem_wen;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rsp_err = 1'b0;
  logic [31:0] ifu_grant_cnt, lsu_grant_cnt;

  int errors = 0;
  int checks = 0;

  // Reference state: grant counts and who was granted last
  int unsigned ifu_cnt_m = 0;
  int unsigned lsu_cnt_m = 0;
  bit          last_lsu_m = 1'b0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_flush(ifu_flush),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .mem_rsp_err(mem_rsp_err),
    .ifu_grant_cnt(ifu_grant_cnt), .lsu_grant_cnt(lsu_grant_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 64'(|{ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
                   lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
                   mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
                   ifu_grant_cnt, lsu_grant_cnt}), 64'(0));
  endtask

  // One transaction. sdly: RSP cycle of the bus response (beyond TO-1 = never
  // in time). fk: RSP cycle carrying an ifu_flush pulse (-1 none).
  // rk: RSP cycle in which reset is asserted (-1 none).
  task automatic txn(input bit iv, input bit lv, input logic [31:0] ia,
                     input logic [31:0] la, input bit we, input logic [31:0] wd,
                     input logic [3:0] wm, input int rdly, input int sdly,
                     input logic [31:0] rd, input bit er, input int fk, input int rk);
    bit win_lsu, dropped, timed;
    int resp_k;
    @(negedge clock);
    ifu_req_valid = iv; ifu_addr = ia;
    lsu_req_valid = lv; lsu_addr = la; lsu_wen = we; lsu_wdata = wd; lsu_wmask = wm;
    if (iv && lv) win_lsu = RR ? !last_lsu_m : 1'b1;
    else          win_lsu = lv;
    #1;
    chk("ifu_req_ready@grant", 64'(ifu_req_ready), 64'(!win_lsu));
    chk("lsu_req_ready@grant", 64'(lsu_req_ready), 64'(win_lsu));
    chk("mem_req_valid@idle", 64'(mem_req_valid), 64'(0));
    if (win_lsu) lsu_cnt_m++; else ifu_cnt_m++;
    last_lsu_m = win_lsu;

    // REQ phase, requesters still asserting valid in the first cycle
    for (int i = 0; i <= rdly; i++) begin
      @(negedge clock);
      mem_req_ready = (i == rdly);
      mem_rsp_valid = (i == 0 && rdly > 0);
      mem_rdata     = 32'hBAD0_0000;
      #1;
      chk("mem_req_valid@req", 64'(mem_req_valid), 64'(1));
      chk("mem_addr", 64'(mem_addr), 64'(win_lsu ? la : ia));
      chk("mem_wen", 64'(mem_wen), 64'(win_lsu && we));
      chk("mem_wmask", 64'(mem_wmask), 64'(win_lsu ? wm : 4'h0));
      if (win_lsu) chk("mem_wdata", 64'(mem_wdata), 64'(wd));
      if (i == 0) begin
        chk("req_ready@req", 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      end
    end

    // RSP phase
    timed   = !(sdly >= 0 && sdly <= TO - 1);
    resp_k  = timed ? TO - 1 : sdly;
    dropped = 1'b0;
    for (int k = 0; k <= resp_k + 1; k++) begin
      @(negedge clock);
      mem_req_ready = 1'b0;
      mem_rsp_valid = (k == sdly);
      mem_rdata     = rd;
      mem_rsp_err   = er;
      ifu_flush     = (k == fk);
      if (k == fk && !win_lsu && k <= resp_k) dropped = 1'b1;
      if (k == rk) begin
        reset = 1'b1;
        #1;
        chk_all_zero("outputs@reset_in_rsp");
        @(negedge clock);
        reset = 1'b0; mem_rsp_valid = 1'b0; ifu_flush = 1'b0;
        ifu_cnt_m = 0; lsu_cnt_m = 0; last_lsu_m = 1'b0;
        return;
      end
      #1;
      if (k == 0) chk("mem_req_valid@rsp", 64'(mem_req_valid), 64'(0));
      if (k <= resp_k) begin
        chk("rsp_valid_early", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(0));
      end else if (win_lsu) begin
        chk("lsu_rsp_valid", 64'(lsu_rsp_valid), 64'(1));
        chk("ifu_rsp_valid@lsu", 64'(ifu_rsp_valid), 64'(0));
        chk("lsu_rsp_err", 64'(lsu_rsp_err), 64'(timed ? 1'b1 : er));
        if (!we || timed) chk("lsu_rdata", 64'(lsu_rdata), 64'(timed ? 32'h0 : rd));
      end else begin
        chk("ifu_rsp_valid", 64'(ifu_rsp_valid), 64'(!dropped));
        chk("lsu_rsp_valid@ifu", 64'(lsu_rsp_valid), 64'(0));
        if (!dropped) begin
          chk("ifu_rsp_err", 64'(ifu_rsp_err), 64'(timed ? 1'b1 : er));
          chk("ifu_rdata", 64'(ifu_rdata), 64'(timed ? 32'h0 : rd));
        end
      end
    end
    @(negedge clock);
    mem_rsp_valid = 1'b0; ifu_flush = 1'b0; mem_rsp_err = 1'b0;
    #1;
    chk("rsp_single_pulse", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(0));
    chk("ifu_grant_cnt", 64'(ifu_grant_cnt), 64'(ifu_cnt_m));
    chk("lsu_grant_cnt", 64'(lsu_grant_cnt), 64'(lsu_cnt_m));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    #1;
    chk_all_zero("outputs@reset");
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_all_zero("outputs@after_reset");

    // Four ties in a row
    for (int t = 0; t < 4; t++)
      txn(1, 1, 32'h8000_0100 + 32'(t * 4), 32'h8000_2000 + 32'(t * 4), 0, '0, 4'h0,
          0, 0, 32'h1111_0000 + 32'(t), 0, -1, -1);
    chk("tie_lsu_cnt", 64'(lsu_grant_cnt), 64'(RR ? 2 : 4));
    chk("tie_ifu_cnt", 64'(ifu_grant_cnt), 64'(RR ? 2 : 0));

    // Single IFU fetch, response one cycle after mem_req_ready
    txn(1, 0, 32'h8000_0000, '0, 0, '0, 4'h0, 0, 0, 32'h0000_0413, 0, -1, -1);

    // LSU store
    txn(0, 1, '0, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 1, 1, 32'h0, 0, -1, -1);

    // Flush in RSP, response 3 cycles later: dropped; then a normal fetch
    txn(1, 0, 32'h8000_0040, '0, 0, '0, 4'h0, 0, 3, 32'h1234_5678, 0, 0, -1);
    txn(1, 0, 32'h8000_0044, '0, 0, '0, 4'h0, 0, 1, 32'hCAFE_F00D, 0, -1, -1);

    // Flush coincident with the response drops it
    txn(1, 0, 32'h8000_0048, '0, 0, '0, 4'h0, 2, 2, 32'h5555_AAAA, 0, 2, -1);

    // Flush during an LSU load has no effect
    txn(0, 1, '0, 32'h8000_3000, 0, '0, 4'h0, 0, 2, 32'h7777_8888, 0, 1, -1);

    // Timeout on an LSU load; the late response lands in IDLE and is ignored
    txn(0, 1, '0, 32'h8000_4000, 0, '0, 4'h0, 0, TO, 32'h9999_9999, 0, -1, -1);

    // Response in the last cycle before timeout wins
    txn(0, 1, '0, 32'h8000_4004, 0, '0, 4'h0, 0, TO - 1, 32'hABCD_0123, 1, -1, -1);

    // A flushed IFU request in IDLE is not granted
    @(negedge clock);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0080; ifu_flush = 1'b1;
    #1;
    chk("ifu_ready@flush_idle", 64'(ifu_req_ready), 64'(0));
    @(negedge clock);
    ifu_req_valid = 1'b0; ifu_flush = 1'b0;
    #1;
    chk("no_req@flush_idle", 64'(mem_req_valid), 64'(0));

    // Reset asserted in RSP, then a fresh fetch
    txn(1, 0, 32'h8000_00C0, '0, 0, '0, 4'h0, 0, 3, 32'h0, 0, -1, 1);
    txn(1, 0, 32'h8000_00C4, '0, 0, '0, 4'h0, 1, 0, 32'h0EAD_BEEF, 0, -1, -1);

    // Randomized transactions
    for (int n = 0; n < 24; n++) begin
      int sel, sd, fk;
      sel = int'($urandom_range(0, 2));
      sd  = int'($urandom_range(0, 4));
      fk  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      if (fk > sd) fk = -1;
      txn(sel != 1, sel != 0, $urandom(), $urandom(), 1'($urandom_range(0, 1)),
          $urandom(), 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), sd,
          $urandom(), $urandom_range(0, 7) == 0, fk, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares a single memory bus between the instruction-fetch requester (IFU) and the load/store requester (LSU) of the pipelined core.
- Sits between the IFU/LSU stages and the memory/bus bridge, and owns the bus for exactly one transaction at a time.
- Suppresses fetch responses invalidated by a control-hazard flush, times out hung transactions, and counts grants for performance analysis.

Parameters:
- ADDR_W, 32, address width of requests and of the memory bus.
- DATA_W, 32, read/write data width; the write mask is DATA_W/8 bits.
- TIMEOUT_CYCLES, 1024, maximum number of cycles in RSP before an error response is forced; must be ≥2.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- ifu_req_valid  in  1  IFU read request valid.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  IFU fetch address.
- ifu_flush  in  1  control hazard; discard any outstanding IFU response.
- ifu_rsp_valid  out  1  one-cycle IFU response pulse.
- ifu_rdata  out  DATA_W  IFU read data.
- ifu_rsp_err  out  1  IFU response error (bus error or timeout).
- lsu_req_valid  in  1  LSU request valid.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  DATA_W/8  store byte mask.
- lsu_rsp_valid  out  1  one-cycle LSU response pulse.
- lsu_rdata  out  DATA_W  load data; don't-care for stores.
- lsu_rsp_err  out  1  LSU response error.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts the request.
- mem_addr  out  ADDR_W  bus address.
- mem_wen  out  1  bus write enable.
- mem_wdata  out  DATA_W  bus write data.
- mem_wmask  out  DATA_W/8  bus byte mask.
- mem_rsp_valid  in  1  bus response valid.
- mem_rdata  in  DATA_W  bus read data.
- mem_rsp_err  in  1  bus response error.
- ifu_grant_cnt  out  32  IFU grants since reset; wraps.
- lsu_grant_cnt  out  32  LSU grants since reset; wraps.

Behaviour:
- Reset values: all outputs 0, state IDLE, owner register cleared, drop flag cleared, timeout counter 0, both grant counters 0.
- Reset mid-transaction aborts the transaction immediately. No response is emitted, and the bus sees mem_req_valid drop to 0.
- The FSM has three states: IDLE, REQ and RSP.

IDLE:
- Grant is decided combinationally from the valid inputs.
- The winner's req_ready=1 in the same cycle; the loser's req_ready=0.
- On grant, latch address, wen, wdata and wmask into the bus registers (IFU grant: wen=0, wmask=0), record the owner, increment the owner's grant counter, and go to REQ.
- An IFU request with ifu_flush=1 in the same cycle is not granted.
- Both req_ready outputs are 0 in REQ and RSP.

REQ:
- mem_req_valid=1 and the bus fields are held stable.
- On mem_req_ready=1, go to RSP and clear the timeout counter.
- Minimum bus-request latency: mem_req_valid is first seen the cycle after grant.

RSP:
- The timeout counter increments every cycle.
- On mem_rsp_valid=1: register rdata and err. In the next cycle, pulse the owner's rsp_valid for exactly one cycle with the registered data. Return to IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES-1 without a response, pulse the owner's rsp_valid with rsp_err=1 and rdata=0 in the next cycle, then return to IDLE.
- If mem_rsp_valid and timeout occur in the same cycle, the real response wins.
- mem_rsp_valid seen in IDLE or REQ is ignored.

Flush:
- ifu_flush=1 while the owner is IFU in REQ or RSP sets the drop flag.
- The bus transaction still completes normally, but ifu_rsp_valid is suppressed.
- The drop flag clears on return to IDLE.
- ifu_flush has no effect on an LSU-owned transaction.
- Flush and mem_rsp_valid in the same cycle: the response is dropped.

Response timing:
- Responses cannot be back-pressured; requesters must accept the rsp_valid pulse.
- Back-to-back throughput: a new grant is possible in the cycle the rsp_valid pulse is emitted. The minimum transaction is 4 cycles (grant, REQ, RSP, response/IDLE) with zero-wait memory.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: ties in IDLE go to the requester that was not granted most recently. A last-grant register resets to IFU, so the first tie goes to the LSU.
- Undefined: fixed priority; the LSU always wins a tie and the last-grant register is not built.

Test Plan:
- Single IFU fetch, addr 0x80000000; memory returns 0x00000413 one cycle after mem_req_ready -> mem_addr=0x80000000, mem_wen=0; ifu_rsp_valid pulses once with ifu_rdata=0x00000413; ifu_grant_cnt=1.
- LSU store, addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF -> bus sees identical fields with mem_wen=1; lsu_rsp_valid pulses once with lsu_rsp_err=0.
- IFU and LSU both valid in IDLE for 4 consecutive transactions:
  - Fixed priority -> LSU granted all 4 times; lsu_grant_cnt=4, ifu_grant_cnt=0.
  - ARB_ROUND_ROBIN_EN -> grant order LSU, IFU, LSU, IFU.
- IFU fetch outstanding; ifu_flush pulsed in RSP; memory responds 3 cycles later -> no ifu_rsp_valid; FSM returns to IDLE; the next IFU request is granted normally.
- TIMEOUT_CYCLES=8, LSU load, memory never responds -> lsu_rsp_valid=1 with lsu_rsp_err=1 and lsu_rdata=0, exactly 8 cycles after entering RSP; a late mem_rsp_valid is ignored.
- reset asserted in RSP -> next cycle all outputs are 0 and state is IDLE; after release, a fresh IFU request completes correctly.
